cpu_sdr_bridge: RTL and testbench
=================================

Name: cpu_sdr_bridge

Overview:
- Sits directly downstream of the 3A address-decode PAL stage on the V30 main CPU bus.
- Takes the decoded SDRAM word address, writable flag and bus-enable, and runs one 16-bit SDRAM access per CPU bus cycle over a toggle req/ack port to the shared SDRAM controller.
- Holds the CPU in wait (cpu_ready low) until read data returns or the write is acknowledged.
- Drops writes to read-only regions and recovers from a stalled controller with a timeout.

Parameters:
- TIMEOUT, 255: cycles to wait for sdr_ack before abandoning an access. Legal range 2..65535.
- ERR_DATA, 16'hFFFF: read data returned to the CPU on timeout.

Ports:
- CLK_32M  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_req  in  1  decoded SDRAM-region access active (ls245_en from 3A stage); level, held for the whole bus cycle.
- cpu_addr  in  24  SDRAM word address [24:1] from 3A stage.
- cpu_writable  in  1  region is RAM (writes allowed).
- cpu_wr  in  1  1 = write cycle, 0 = read.
- cpu_be  in  2  byte enables {upper, lower}, active-high.
- cpu_dout  in  16  CPU write data.
- cpu_din  out  16  read data to CPU.
- cpu_ready  out  1  high = access complete / bus idle; low = insert wait states.
- sdr_req  out  1  request toggle to SDRAM controller.
- sdr_ack  in  1  controller acknowledge; access complete when sdr_ack == sdr_req.
- sdr_addr  out  24  registered word address.
- sdr_we  out  1  write strobe qualifier.
- sdr_be  out  2  byte enables.
- sdr_data  out  16  write data.
- sdr_q  in  16  read data; valid in the cycle sdr_ack matches sdr_req.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset values:
  - cpu_din = 0, cpu_ready = 1, sdr_req = 0, sdr_addr = 0, sdr_we = 0, sdr_be = 0, sdr_data = 0, timeout_err = 0.
  - State = IDLE; timeout counter = 0.
  - Reset also resynchronises sdr_req to the current sdr_ack so no spurious completion occurs.
- States: IDLE, ACCESS, HOLD.
- IDLE, cpu_mem_req = 1:
  - Latch addr, wr, be, dout into the sdr_* registers.
  - Drive cpu_ready = 0 the next cycle.
  - If cpu_wr & !cpu_writable: no SDRAM access, go to HOLD with cpu_ready = 1 on the next cycle (write silently dropped; 2-cycle latency).
  - Otherwise toggle sdr_req, set sdr_we = cpu_wr, clear the counter, go to ACCESS.
- ACCESS:
  - Counter increments each cycle.
  - If sdr_ack == sdr_req: on a read, latch sdr_q into cpu_din. Set cpu_ready = 1, go to HOLD.
  - Else if counter == TIMEOUT-1: cpu_din = ERR_DATA (reads only), set timeout_err, cpu_ready = 1, go to HOLD.
  - A late ack after a timeout is ignored: sdr_req is re-aligned to sdr_ack on leaving ACCESS.
- HOLD:
  - cpu_ready stays 1 and cpu_din stays stable.
  - Go to IDLE when cpu_mem_req = 0.
  - A cpu_mem_req that is held high never starts a second access.
- Minimum read latency: request seen in cycle 0, sdr_req toggles at the cycle-1 edge, ack at the earliest in cycle 2, cpu_ready = 1 in cycle 3.
- The CPU samples ready no earlier than 2 cycles after asserting its request, so the registered cpu_ready drop is always seen in time.
- cpu_mem_req dropping while in ACCESS: the SDRAM access still completes (no abort), then go directly to IDLE.
- sdr_addr, sdr_we, sdr_be and sdr_data are stable from the toggle until completion.
- Reset mid-ACCESS: return to IDLE at once. Any ack the controller later produces is absorbed by the realignment rule.

Optional Feature:
- CPU_SDR_RDCACHE_EN: one-entry read cache holding {valid, addr, data}.
- Defined:
  - A read whose cpu_addr matches a valid entry skips SDRAM and goes to HOLD with cached data (2-cycle latency).
  - Every completed read fills the entry.
  - A write to the matching address updates the cached bytes per cpu_be.
  - The entry is invalidated on reset and on timeout.
- Undefined: every read goes to SDRAM; no cache registers are synthesised.

Decomposition:
- m72_pkg gains:
  - the bridge_state_t enum (IDLE/ACCESS/HOLD);
  - the default TIMEOUT constant;
  - the existing REGION base addresses, referenced by the bench only.
- Sub-module sdr_toggle_port: owns the sdr_req toggle, the ack comparison, the realignment and the timeout counter, and exposes start/done/timed_out.

Test Plan:
- RAM read: cpu_addr = 24'h040010, ack 4 cycles after toggle, sdr_q = 16'h1234 -> cpu_din = 16'h1234, cpu_ready high exactly one cycle after ack match, single sdr_req toggle.
- RAM write: cpu_wr = 1, cpu_be = 2'b01, dout = 16'hABCD, writable = 1 -> sdr_we = 1, sdr_be = 01, sdr_data = ABCD held until ack; cpu_ready high after ack.
- ROM write: writable = 0, cpu_wr = 1 -> sdr_req never toggles, cpu_ready low for 1 cycle then high; timeout_err stays 0.
- Timeout: TIMEOUT = 8, read, no ack -> cpu_ready high after 8 cycles in ACCESS, cpu_din = FFFF, timeout_err = 1; late ack 5 cycles later -> no state change; next read completes normally.
- Back-to-back and held request: cpu_mem_req held high 20 cycles -> exactly one access. Drop 1 cycle, reassert -> second access. Reset asserted mid-ACCESS -> outputs at reset values, next access correct.
- With CPU_SDR_RDCACHE_EN: read X (miss), read X again -> no toggle, cpu_ready after 2 cycles, same data. Write X byte 0 = 0x55, then read X -> cached low byte 0x55.

Source files
------------

// File: rtl/m72_pkg.sv
// Shared M72 bus definitions: bridge FSM states, default SDRAM access timeout
// and the CPU-visible region base addresses.
package m72_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        HOLD   = 2'd2
    } bridge_state_t;

    localparam int SDR_TIMEOUT_DEFAULT = 255;

    // Word-address bases of the decoded regions.
    localparam logic [23:0] REGION_ROM_BASE = 24'h000000;
    localparam logic [23:0] REGION_RAM_BASE = 24'h040000;

endpackage

// File: rtl/cpu_sdr_bridge_port.sv
// Toggle req/ack handshake to the SDRAM controller with access timeout.
// sdr_req follows sdr_ack whenever no access is outstanding, absorbing late acks.
module sdr_toggle_port
    import m72_pkg::*;
#(
    parameter int TIMEOUT = SDR_TIMEOUT_DEFAULT
) (
    input  logic CLK_32M,
    input  logic reset,
    input  logic start,
    input  logic sdr_ack,
    output logic sdr_req,
    output logic done,
    output logic timed_out
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT - 1);

    logic        active;
    logic [15:0] count;

    assign done      = active && (sdr_ack == sdr_req);
    assign timed_out = active && (sdr_ack != sdr_req) && (count == LAST_COUNT);

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            sdr_req <= sdr_ack;
            active  <= 1'b0;
            count   <= 16'd0;
        end else if (start) begin
            // Toggle relative to ack so an ack landing this cycle cannot fake completion.
            sdr_req <= ~sdr_ack;
            active  <= 1'b1;
            count   <= 16'd0;
        end else if (active) begin
            count <= count + 16'd1;
            if (done || timed_out) begin
                active  <= 1'b0;
                sdr_req <= sdr_ack;
            end
        end else begin
            sdr_req <= sdr_ack;
        end
    end

endmodule

// File: rtl/cpu_sdr_bridge.sv
// V30 bus to SDRAM bridge: one 16-bit access per CPU bus cycle, wait states via cpu_ready.
// Optional one-entry read cache when CPU_SDR_RDCACHE_EN is defined.
module cpu_sdr_bridge
    import m72_pkg::*;
#(
    parameter int          TIMEOUT  = SDR_TIMEOUT_DEFAULT,
    parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic        cpu_mem_req,
    input  logic [23:0] cpu_addr,
    input  logic        cpu_writable,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_ready,
    output logic        sdr_req,
    input  logic        sdr_ack,
    output logic [23:0] sdr_addr,
    output logic        sdr_we,
    output logic [1:0]  sdr_be,
    output logic [15:0] sdr_data,
    input  logic [15:0] sdr_q,
    output logic        timeout_err
);

    bridge_state_t state_q, state_d;
    logic          start, done, timed_out;
    logic          cache_hit;
    logic [15:0]   cache_data;

    sdr_toggle_port #(.TIMEOUT(TIMEOUT)) u_port (
        .CLK_32M   (CLK_32M),
        .reset     (reset),
        .start     (start),
        .sdr_ack   (sdr_ack),
        .sdr_req   (sdr_req),
        .done      (done),
        .timed_out (timed_out)
    );

    always_ff @(posedge CLK_32M) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_mem_req) begin
                    if ((cpu_wr && !cpu_writable) || cache_hit) begin
                        state_d = HOLD;
                    end else begin
                        start   = 1'b1;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A bus cycle abandoned by the CPU still completes, then skips HOLD.
                if (done || timed_out) state_d = cpu_mem_req ? HOLD : IDLE;
            end
            HOLD: begin
                if (!cpu_mem_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            cpu_din     <= 16'h0000;
            cpu_ready   <= 1'b1;
            sdr_addr    <= 24'h000000;
            sdr_we      <= 1'b0;
            sdr_be      <= 2'b00;
            sdr_data    <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cpu_mem_req) begin
                        sdr_addr  <= cpu_addr;
                        sdr_we    <= cpu_wr & cpu_writable;
                        sdr_be    <= cpu_be;
                        sdr_data  <= cpu_dout;
                        cpu_ready <= 1'b0;
                        if (cache_hit) cpu_din <= cache_data;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        if (!sdr_we) cpu_din <= sdr_q;
                        cpu_ready <= 1'b1;
                    end else if (timed_out) begin
                        if (!sdr_we) cpu_din <= ERR_DATA;
                        timeout_err <= 1'b1;
                        cpu_ready   <= 1'b1;
                    end
                end
                HOLD:    cpu_ready <= 1'b1;
                default: cpu_ready <= 1'b1;
            endcase
        end
    end

`ifdef CPU_SDR_RDCACHE_EN
    logic        c_valid;
    logic [23:0] c_addr;
    logic [15:0] c_data;

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            c_valid <= 1'b0;
            c_addr  <= 24'h000000;
            c_data  <= 16'h0000;
        end else if (timed_out) begin
            c_valid <= 1'b0;
        end else if (done) begin
            if (!sdr_we) begin
                c_valid <= 1'b1;
                c_addr  <= sdr_addr;
                c_data  <= sdr_q;
            end else if (c_valid && (c_addr == sdr_addr)) begin
                if (sdr_be[0]) c_data[7:0]  <= sdr_data[7:0];
                if (sdr_be[1]) c_data[15:8] <= sdr_data[15:8];
            end
        end
    end

    assign cache_hit  = c_valid && !cpu_wr && (c_addr == cpu_addr);
    assign cache_data = c_data;
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_sdr_bridge.sv
// Bench for cpu_sdr_bridge: vector table, corner-case sequences and random
// accesses against a word-memory model of the SDRAM behind the controller.
module tb_cpu_sdr_bridge;
    import m72_pkg::*;

    localparam int TO = 8;
`ifdef CPU_SDR_RDCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic        CLK_32M = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_mem_req = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic        cpu_writable = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [1:0]  cpu_be = '0;
    logic [15:0] cpu_dout = '0;
    logic [15:0] cpu_din;
    logic        cpu_ready;
    logic        sdr_req;
    logic        sdr_ack = 1'b0;
    logic [23:0] sdr_addr;
    logic        sdr_we;
    logic [1:0]  sdr_be;
    logic [15:0] sdr_data;
    logic [15:0] sdr_q = '0;
    logic        timeout_err;

    cpu_sdr_bridge #(.TIMEOUT(TO), .ERR_DATA(16'hFFFF)) dut (
        .CLK_32M(CLK_32M), .reset(reset), .cpu_mem_req(cpu_mem_req), .cpu_addr(cpu_addr),
        .cpu_writable(cpu_writable), .cpu_wr(cpu_wr), .cpu_be(cpu_be), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_ready(cpu_ready), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
        .sdr_addr(sdr_addr), .sdr_we(sdr_we), .sdr_be(sdr_be), .sdr_data(sdr_data),
        .sdr_q(sdr_q), .timeout_err(timeout_err)
    );

    always #5 CLK_32M = ~CLK_32M;

    int n_cmp = 0;
    int n_bad = 0;

    // SDRAM contents, bridge-visible state expected from the rules
    logic [15:0] mem [logic [23:0]];
    logic [15:0] last_din = '0;
    bit          err_m = 1'b0;
    bit          c_valid_m = 1'b0;
    logic [23:0] c_addr_m = '0;

    typedef struct {
        bit          wr;
        bit          wrable;
        logic [1:0]  be;
        logic [23:0] addr;
        logic [15:0] dout;
        int          dly;
        logic [15:0] exp_din;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'hC35A;
    endfunction

    function automatic bit model_hit(input bit wr, input logic [23:0] a);
        return CACHE_EN && !wr && c_valid_m && (c_addr_m == a);
    endfunction

    task automatic predict(input bit wr, input bit wrable, input logic [23:0] a, input int dly,
                           output int lat, output logic [15:0] din);
        if ((wr && !wrable) || model_hit(wr, a)) begin
            lat = 2;
            din = wr ? last_din : mem_rd(a);
        end else if (dly > TO - 1) begin
            lat = TO + 1;
            din = wr ? last_din : 16'hFFFF;
        end else begin
            lat = dly + 2;
            din = wr ? last_din : mem_rd(a);
        end
    endtask

    // Runs one bus cycle; the controller acks dly cycles after seeing the toggle.
    task automatic do_access(input bit wr, input bit wrable, input logic [1:0] be,
                             input logic [23:0] a, input logic [15:0] dout, input int dly,
                             input int exp_lat, input logic [15:0] exp_din, input string tag);
        bit drop, hit, acc, to, acked, stable;
        int cyc, since, tog;
        logic prev_req;
        logic [15:0] m;
        drop = wr && !wrable;
        hit  = model_hit(wr, a);
        acc  = !drop && !hit;
        to   = acc && (dly > TO - 1);
        cpu_wr = wr; cpu_writable = wrable; cpu_be = be; cpu_addr = a; cpu_dout = dout;
        cpu_mem_req = 1'b1;
        prev_req = sdr_req;
        cyc = 0; since = -1; tog = 0; acked = 1'b0; stable = 1'b1;
        while (cyc < 100) begin
            @(negedge CLK_32M);
            cyc++;
            if (sdr_req !== prev_req && !cpu_ready) tog++;
            prev_req = sdr_req;
            if (cpu_ready) break;
            if (since < 0) begin
                if (sdr_req != sdr_ack) since = 0;
            end else if (!acked) begin
                since++;
            end
            if (since >= 0 && !acked) begin
                if (sdr_addr !== a || sdr_we !== wr || sdr_be !== be || sdr_data !== dout)
                    stable = 1'b0;
                if (since == dly) begin
                    if (wr) begin
                        m = mem_rd(a);
                        if (be[0]) m[7:0]  = dout[7:0];
                        if (be[1]) m[15:8] = dout[15:8];
                        mem[a] = m;
                    end else begin
                        sdr_q = mem_rd(a);
                    end
                    sdr_ack = sdr_req;
                    acked = 1'b1;
                end
            end
        end
        chk({tag, " ready"}, cpu_ready, 1);
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " toggles"}, tog, acc);
        chk({tag, " din"}, cpu_din, exp_din);
        chk({tag, " timeout_err"}, timeout_err, err_m | to);
        if (acc) chk({tag, " sdr stable"}, stable, 1);
        if (to) begin
            err_m = 1'b1;
            c_valid_m = 1'b0;
        end else if (acc && !wr) begin
            c_valid_m = 1'b1;
            c_addr_m = a;
        end
        last_din = exp_din;
    endtask

    task automatic release_bus();
        cpu_mem_req = 1'b0;
        @(negedge CLK_32M);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " cpu_din"}, cpu_din, 0);
        chk({tag, " cpu_ready"}, cpu_ready, 1);
        chk({tag, " sdr_req"}, sdr_req, sdr_ack);
        chk({tag, " sdr_addr"}, sdr_addr, 0);
        chk({tag, " sdr_we"}, sdr_we, 0);
        chk({tag, " sdr_be"}, sdr_be, 0);
        chk({tag, " sdr_data"}, sdr_data, 0);
        chk({tag, " timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [10];
        int lat, tog;
        logic [15:0] din;
        logic prev;
        bit rdy_ok;

        vt[0] = '{0, 1, 2'b11, REGION_RAM_BASE + 24'h10, 16'h0000, 4, 16'h1234, 6};
        vt[1] = '{1, 1, 2'b01, REGION_RAM_BASE + 24'h10, 16'hABCD, 3, 16'h1234, 5};
        vt[2] = '{0, 1, 2'b11, 24'h000200,               16'h0000, 1, 16'hC15A, 3};
        vt[3] = '{0, 1, 2'b11, REGION_RAM_BASE + 24'h10, 16'h0000, 1, 16'h12CD, 3};
        vt[4] = '{1, 0, 2'b11, REGION_ROM_BASE + 24'h100, 16'h9999, 1, 16'h12CD, 2};
        vt[5] = '{0, 1, 2'b11, 24'h000100,               16'h0000, 7, 16'hC25A, 9};
        vt[6] = '{1, 1, 2'b10, 24'h000100,               16'h7788, 2, 16'hC25A, 4};
        vt[7] = '{0, 1, 2'b11, 24'h123456,               16'h0000, 2, 16'hF70C, 4};
        vt[8] = '{0, 1, 2'b11, 24'h000100,               16'h0000, 1, 16'h775A, 3};
        vt[9] = '{0, 1, 2'b11, 24'hFFFFFF,               16'h0000, 8, 16'hFFFF, 9};
        mem[REGION_RAM_BASE + 24'h10] = 16'h1234;

        repeat (2) @(negedge CLK_32M);
        check_reset_vals("reset");
        chk("reset sdr_req zero", sdr_req, 0);
        reset = 1'b0;
        @(negedge CLK_32M);

        for (int i = 0; i < 10; i++) begin
            do_access(vt[i].wr, vt[i].wrable, vt[i].be, vt[i].addr, vt[i].dout, vt[i].dly,
                      vt[i].exp_lat, vt[i].exp_din, $sformatf("vec%0d", i));
            release_bus();
        end

        // Timeout, then a late ack while the CPU still holds the cycle
        predict(0, 1, REGION_RAM_BASE + 24'h300, 30, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h300, 16'h0, 30, lat, din, "timeout");
        repeat (5) @(negedge CLK_32M);
        sdr_ack = ~sdr_ack;
        repeat (3) @(negedge CLK_32M);
        chk("late ack ready", cpu_ready, 1);
        chk("late ack din", cpu_din, 16'hFFFF);
        chk("late ack err", timeout_err, 1);
        chk("late ack realign", sdr_req, sdr_ack);
        release_bus();
        predict(0, 1, REGION_RAM_BASE + 24'h300, 2, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h300, 16'h0, 2, lat, din, "post timeout");
        release_bus();

        // Request held high for 20 cycles, then dropped for one and reasserted
        predict(0, 1, REGION_RAM_BASE + 24'h20, 3, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h20, 16'h0, 3, lat, din, "held");
        tog = 0; prev = sdr_req; rdy_ok = 1'b1;
        repeat (20) begin
            @(negedge CLK_32M);
            if (sdr_req !== prev) tog++;
            prev = sdr_req;
            if (!cpu_ready) rdy_ok = 1'b0;
        end
        chk("held toggles", tog, 0);
        chk("held ready", rdy_ok, 1);
        release_bus();
        predict(0, 1, REGION_RAM_BASE + 24'h20, 2, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h20, 16'h0, 2, lat, din, "reassert");
        release_bus();

        // Reset in the middle of an access; the controller's ack arrives afterwards
        cpu_wr = 1'b0; cpu_writable = 1'b1; cpu_be = 2'b11;
        cpu_addr = REGION_RAM_BASE + 24'h30; cpu_mem_req = 1'b1;
        repeat (3) @(negedge CLK_32M);
        chk("mid access waiting", cpu_ready, 0);
        reset = 1'b1;
        cpu_mem_req = 1'b0;
        @(negedge CLK_32M);
        check_reset_vals("mid reset");
        reset = 1'b0;
        last_din = '0; err_m = 1'b0; c_valid_m = 1'b0;
        repeat (2) @(negedge CLK_32M);
        sdr_ack = ~sdr_ack;
        repeat (2) @(negedge CLK_32M);
        chk("absorbed ack", sdr_req, sdr_ack);
        chk("absorbed ready", cpu_ready, 1);
        predict(0, 1, REGION_RAM_BASE + 24'h30, 3, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h30, 16'h0, 3, lat, din, "after reset");
        release_bus();

        for (int i = 0; i < 40; i++) begin
            bit wr, wrable;
            logic [1:0] be;
            logic [23:0] a;
            logic [15:0] dout;
            int d;
            wr     = 1'($urandom_range(0, 1));
            wrable = ($urandom_range(0, 3) != 0);
            be     = 2'($urandom_range(0, 3));
            a      = REGION_RAM_BASE + 24'($urandom_range(0, 3));
            dout   = 16'($urandom);
            d      = wr ? int'($urandom_range(1, TO - 1)) : int'($urandom_range(1, TO + 1));
            predict(wr, wrable, a, d, lat, din);
            do_access(wr, wrable, be, a, dout, d, lat, din, $sformatf("rnd%0d", i));
            release_bus();
        end

`ifdef CPU_SDR_RDCACHE_EN
        predict(0, 1, REGION_RAM_BASE + 24'h40, 3, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h40, 16'h0, 3, lat, din, "cache miss");
        release_bus();
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h40, 16'h0, 3, 2, din, "cache hit");
        release_bus();
        predict(1, 1, REGION_RAM_BASE + 24'h40, 2, lat, din);
        do_access(1, 1, 2'b01, REGION_RAM_BASE + 24'h40, 16'h0055, 2, lat, din, "cache write");
        release_bus();
        predict(0, 1, REGION_RAM_BASE + 24'h40, 3, lat, din);
        do_access(0, 1, 2'b11, REGION_RAM_BASE + 24'h40, 16'h0, 3, lat, din, "cache reread");
        chk("cache low byte", cpu_din[7:0], 8'h55);
        release_bus();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
